// File: rtl/reg_to_axi_lite_if.sv
// Register-bus and AXI4-Lite interface definitions
// shared by the bridge and its environment.
interface REG_BUS #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    write;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    valid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    error;
  logic                    ready;

  modport in (
    input  addr, write, wdata, wstrb, valid,
    output rdata, error, ready
  );

  modport out (
    output addr, write, wdata, wstrb, valid,
    input  rdata, error, ready
  );
endinterface

interface AXI_LITE #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [2:0]              aw_prot;
  logic                    aw_valid;
  logic                    aw_ready;

  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_valid;
  logic                    w_ready;

  logic [1:0]              b_resp;
  logic                    b_valid;
  logic                    b_ready;

  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [2:0]              ar_prot;
  logic                    ar_valid;
  logic                    ar_ready;

  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_valid;
  logic                    r_ready;

  modport Master (
    output aw_addr, aw_prot, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_valid,
    input  w_ready,
    input  b_resp, b_valid,
    output b_ready,
    output ar_addr, ar_prot, ar_valid,
    input  ar_ready,
    input  r_data, r_resp, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_addr, aw_prot, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_valid,
    output w_ready,
    output b_resp, b_valid,
    input  b_ready,
    input  ar_addr, ar_prot, ar_valid,
    output ar_ready,
    output r_data, r_resp, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/reg_to_axi_lite.sv
// Register-interface to AXI4-Lite master bridge.
// One transaction in flight, all outputs registered.
module reg_to_axi_lite #(
  parameter int ADDR_WIDTH = -1,
  parameter int DATA_WIDTH = -1
) (
  input logic      clk_i,
  input logic      rst_i,
  REG_BUS.in       reg_i,
  AXI_LITE.Master  axi_o
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  error_q, error_d;

  logic aw_done_q, aw_done_d;
  logic w_done_q, w_done_d;

  logic aw_valid_q, aw_valid_d;
  logic w_valid_q, w_valid_d;
  logic ar_valid_q, ar_valid_d;
  logic b_ready_q, b_ready_d;
  logic r_ready_q, r_ready_d;
  logic ready_q, ready_d;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    error_d   = error_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;

    unique case (state_q)
      IDLE: begin
        if (reg_i.valid) begin
          addr_d    = reg_i.addr;
          wdata_d   = reg_i.wdata;
          wstrb_d   = reg_i.wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = reg_i.write ? WR_REQ
                                  : RD_REQ;
        end
      end
      WR_REQ: begin
        // AW and W complete independently
        if (aw_valid_q && axi_o.aw_ready)
          aw_done_d = 1'b1;
        if (w_valid_q && axi_o.w_ready)
          w_done_d = 1'b1;
        if (aw_done_d && w_done_d)
          state_d = WR_RESP;
      end
      WR_RESP: begin
        if (axi_o.b_valid) begin
          error_d = axi_o.b_resp[1];
          rdata_d = '0;
          state_d = DONE;
        end
      end
      RD_REQ: begin
        if (axi_o.ar_ready)
          state_d = RD_RESP;
      end
      RD_RESP: begin
        if (axi_o.r_valid) begin
          rdata_d = axi_o.r_data;
          error_d = axi_o.r_resp[1];
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // output flops are loaded from the next state
  always_comb begin
    aw_valid_d = (state_d == WR_REQ)
               && !aw_done_d;
    w_valid_d  = (state_d == WR_REQ)
               && !w_done_d;
    ar_valid_d = (state_d == RD_REQ);
    b_ready_d  = (state_d == WR_RESP);
    r_ready_d  = (state_d == RD_RESP);
    ready_d    = (state_d == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      error_q    <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      b_ready_q  <= 1'b0;
      r_ready_q  <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      rdata_q    <= rdata_d;
      error_q    <= error_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      ar_valid_q <= ar_valid_d;
      b_ready_q  <= b_ready_d;
      r_ready_q  <= r_ready_d;
      ready_q    <= ready_d;
    end
  end

  assign reg_i.ready    = ready_q;
  assign reg_i.rdata    = rdata_q;
  assign reg_i.error    = error_q;

  assign axi_o.aw_addr  = addr_q;
  assign axi_o.aw_prot  = 3'b000;
  assign axi_o.aw_valid = aw_valid_q;
  assign axi_o.w_data   = wdata_q;
  assign axi_o.w_strb   = wstrb_q;
  assign axi_o.w_valid  = w_valid_q;
  assign axi_o.b_ready  = b_ready_q;
  assign axi_o.ar_addr  = addr_q;
  assign axi_o.ar_prot  = 3'b000;
  assign axi_o.ar_valid = ar_valid_q;
  assign axi_o.r_ready  = r_ready_q;

  // only bit 1 of a response distinguishes errors
  logic unused_resp;
  assign unused_resp = axi_o.b_resp[0]
                     ^ axi_o.r_resp[0];

endmodule

// File: tb/tb_reg_to_axi_lite.sv
// Self-checking bench for reg_to_axi_lite with a
// delay-programmable AXI-Lite subordinate model.
module tb_reg_to_axi_lite;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  REG_BUS  #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) reg_bus ();
  AXI_LITE #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

  reg_to_axi_lite #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .reg_i (reg_bus),
    .axi_o (axi)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          aw_w;
    int          w_w;
    int          b_w;
    int          ar_w;
    int          r_w;
    logic [1:0]  resp;
    logic [31:0] rdat;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  int total = 0;
  int passed = 0;
  int viol_n = 0;

  int cfg_aw, cfg_w, cfg_b, cfg_ar, cfg_r;
  logic [1:0]  cfg_resp;
  logic [31:0] cfg_rdat;
  logic        stray = 1'b0;

  int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  logic b_pend, r_pend, aw_got, w_got;
  int aw_n = 0, w_n = 0, b_n = 0;
  int ar_n = 0, r_n = 0, rdy_n = 0;
  logic [31:0] aw_log[$];
  logic [35:0] w_log[$];
  logic [31:0] ar_log[$];

  logic p_aw_hs, p_w_hs, p_ar_hs;
  logic p_aw_wait, p_w_wait, p_ar_wait;
  logic p_ready;
  logic [31:0] p_aw_addr, p_ar_addr;
  logic [35:0] p_w;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h",
                  name, act, exp);
  endtask

  task automatic viol(input string s);
    viol_n++;
    $display("FAIL proto %s at %0t", s, $time);
  endtask

  // subordinate: readies/valids set mid-cycle
  always @(negedge clk) begin
    axi.aw_ready = axi.aw_valid && (aw_cnt >= cfg_aw);
    axi.w_ready  = axi.w_valid && (w_cnt >= cfg_w);
    axi.ar_ready = axi.ar_valid && (ar_cnt >= cfg_ar);
    axi.b_valid  = stray || (b_pend && (b_cnt >= cfg_b));
    axi.r_valid  = stray || (r_pend && (r_cnt >= cfg_r));
    axi.b_resp   = cfg_resp;
    axi.r_resp   = cfg_resp;
    axi.r_data   = cfg_rdat;
  end

  // observer and subordinate bookkeeping
  always @(posedge clk) begin
    logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
    if (rst) begin
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
      b_cnt = 0; r_cnt = 0;
      b_pend = 0; r_pend = 0;
      aw_got = 0; w_got = 0;
      p_aw_hs = 0; p_w_hs = 0; p_ar_hs = 0;
      p_aw_wait = 0; p_w_wait = 0; p_ar_wait = 0;
      p_ready = 0;
    end else begin
      aw_hs = axi.aw_valid && axi.aw_ready;
      w_hs  = axi.w_valid && axi.w_ready;
      ar_hs = axi.ar_valid && axi.ar_ready;
      b_hs  = axi.b_valid && axi.b_ready;
      r_hs  = axi.r_valid && axi.r_ready;
      if (p_aw_hs && axi.aw_valid) viol("aw_valid after hs");
      if (p_aw_wait && (!axi.aw_valid ||
          axi.aw_addr != p_aw_addr)) viol("aw unstable");
      if (p_w_hs && axi.w_valid) viol("w_valid after hs");
      if (p_w_wait && (!axi.w_valid ||
          {axi.w_strb, axi.w_data} != p_w)) viol("w unstable");
      if (p_ar_hs && axi.ar_valid) viol("ar_valid after hs");
      if (p_ar_wait && (!axi.ar_valid ||
          axi.ar_addr != p_ar_addr)) viol("ar unstable");
      if (axi.aw_valid && axi.aw_prot != 3'b000) viol("aw_prot");
      if (axi.ar_valid && axi.ar_prot != 3'b000) viol("ar_prot");
      if (axi.b_ready && !(aw_got && w_got)) viol("b_ready early");
      if (p_ready && reg_bus.ready) viol("ready > 1 cycle");
      if (reg_bus.ready) rdy_n++;
      if (b_hs) begin
        b_n++; b_pend = 0; aw_got = 0; w_got = 0;
      end else if (b_pend) b_cnt++;
      if (aw_hs) begin
        aw_n++; aw_log.push_back(axi.aw_addr);
        aw_got = 1; aw_cnt = 0;
      end else if (axi.aw_valid) aw_cnt++;
      if (w_hs) begin
        w_n++; w_log.push_back({axi.w_strb, axi.w_data});
        w_got = 1; w_cnt = 0;
      end else if (axi.w_valid) w_cnt++;
      if (aw_got && w_got && !b_pend && !b_hs) begin
        b_pend = 1; b_cnt = 0;
      end
      if (r_hs) begin
        r_n++; r_pend = 0;
      end else if (r_pend) r_cnt++;
      if (ar_hs) begin
        ar_n++; ar_log.push_back(axi.ar_addr);
        r_pend = 1; r_cnt = 0; ar_cnt = 0;
      end else if (axi.ar_valid) ar_cnt++;
      p_aw_hs = aw_hs; p_w_hs = w_hs; p_ar_hs = ar_hs;
      p_aw_wait = axi.aw_valid && !axi.aw_ready;
      p_w_wait  = axi.w_valid && !axi.w_ready;
      p_ar_wait = axi.ar_valid && !axi.ar_ready;
      p_aw_addr = axi.aw_addr;
      p_ar_addr = axi.ar_addr;
      p_w = {axi.w_strb, axi.w_data};
      p_ready = reg_bus.ready;
    end
  end

  function automatic int model_lat(input vec_t v);
    int m;
    m = (v.aw_w > v.w_w) ? v.aw_w : v.w_w;
    return v.wr ? 3 + m + v.b_w : 3 + v.ar_w + v.r_w;
  endfunction

  task automatic set_cfg(input vec_t v);
    cfg_aw = v.aw_w; cfg_w = v.w_w; cfg_b = v.b_w;
    cfg_ar = v.ar_w; cfg_r = v.r_w;
    cfg_resp = v.resp; cfg_rdat = v.rdat;
  endtask

  task automatic wait_ready(output int lat,
                            output int first,
                            output logic to);
    lat = 0; first = -1; to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (first < 0 && (axi.aw_valid || axi.ar_valid))
        first = lat;
      if (reg_bus.ready) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    int lat, first;
    logic to;
    logic [31:0] rd;
    logic er;
    int aw0, w0, b0, ar0, r0, rdy0;
    aw0 = aw_n; w0 = w_n; b0 = b_n;
    ar0 = ar_n; r0 = r_n; rdy0 = rdy_n;
    @(negedge clk);
    set_cfg(v);
    reg_bus.write = v.wr;
    reg_bus.addr  = v.addr;
    reg_bus.wdata = v.wdata;
    reg_bus.wstrb = v.strb;
    reg_bus.valid = 1'b1;
    wait_ready(lat, first, to);
    rd = reg_bus.rdata;
    er = reg_bus.error;
    // valid stays high through DONE on purpose
    @(negedge clk);
    reg_bus.valid = 1'b0;
    check({tag, "_timeout"}, 64'(to), 64'(0));
    check({tag, "_rdata"}, 64'(rd), 64'(v.exp_rdata));
    check({tag, "_error"}, 64'(er), 64'(v.exp_err));
    check({tag, "_latency"}, 64'(lat), 64'(v.exp_lat));
    check({tag, "_req_cycle"}, 64'(first), 64'(1));
    if (v.wr) begin
      check({tag, "_aw_addr"}, 64'(aw_log[$]), 64'(v.addr));
      check({tag, "_w_beat"}, 64'(w_log[$]),
            64'({v.strb, v.wdata}));
    end else begin
      check({tag, "_ar_addr"}, 64'(ar_log[$]), 64'(v.addr));
    end
    check({tag, "_counts"},
          {8'(aw_n - aw0), 8'(w_n - w0), 8'(b_n - b0),
           8'(ar_n - ar0), 8'(r_n - r0), 8'(rdy_n - rdy0)},
          {8'(v.wr), 8'(v.wr), 8'(v.wr),
           8'(!v.wr), 8'(!v.wr), 8'd1});
  endtask

  function automatic logic [63:0] out_bus();
    return {axi.aw_valid, axi.w_valid, axi.ar_valid,
            axi.b_ready, axi.r_ready, reg_bus.ready,
            reg_bus.error, reg_bus.rdata};
  endfunction

  vec_t tbl[8];
  vec_t zv;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, first;
    logic to;
    int ar0, aw0, rdy0, b0, r0;
    vec_t rv;

    zv = '{wr: 0, addr: 0, wdata: 0, strb: 0, aw_w: 0,
           w_w: 0, b_w: 0, ar_w: 0, r_w: 0, resp: 0,
           rdat: 0, exp_rdata: 0, exp_err: 0, exp_lat: 3};
    tbl[0] = '{1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0,
               2'b00, 32'h0, 32'h0, 0, 3};
    tbl[1] = '{0, 32'h24, 32'h0, 4'h0, 0, 0, 0, 0, 0,
               2'b10, 32'h12345678, 32'h12345678, 1, 3};
    tbl[2] = '{1, 32'h30, 32'hA5A5A5A5, 4'h5, 3, 0, 0, 0, 0,
               2'b00, 32'h0, 32'h0, 0, 6};
    tbl[3] = '{1, 32'h34, 32'h0BADF00D, 4'hA, 0, 3, 0, 0, 0,
               2'b00, 32'h0, 32'h0, 0, 6};
    tbl[4] = '{0, 32'h40, 32'h0, 4'h0, 0, 0, 0, 5, 7,
               2'b00, 32'hCAFEF00D, 32'hCAFEF00D, 0, 15};
    tbl[5] = '{1, 32'h0, 32'h1, 4'hF, 0, 0, 0, 0, 0,
               2'b11, 32'h0, 32'h0, 1, 3};
    tbl[6] = '{0, 32'h44, 32'h0, 4'h0, 0, 0, 0, 0, 0,
               2'b01, 32'h55AA55AA, 32'h55AA55AA, 0, 3};
    tbl[7] = '{1, 32'h8, 32'h77, 4'h3, 0, 0, 4, 0, 0,
               2'b10, 32'h0, 32'h0, 1, 7};

    set_cfg(zv);
    reg_bus.valid = 0; reg_bus.write = 0;
    reg_bus.addr = 0; reg_bus.wdata = 0; reg_bus.wstrb = 0;
    repeat (3) @(negedge clk);
    check("reset_outputs", out_bus(), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check("idle_outputs", out_bus(), 64'(0));

    for (int i = 0; i < 8; i++)
      apply(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 30; i++) begin
      rv = zv;
      rv.wr    = 1'($urandom_range(0, 1));
      rv.addr  = $urandom;
      rv.wdata = $urandom;
      rv.strb  = 4'($urandom_range(0, 15));
      rv.aw_w  = $urandom_range(0, 3);
      rv.w_w   = $urandom_range(0, 3);
      rv.b_w   = $urandom_range(0, 3);
      rv.ar_w  = $urandom_range(0, 3);
      rv.r_w   = $urandom_range(0, 3);
      rv.resp  = 2'($urandom_range(0, 3));
      rv.rdat  = $urandom;
      rv.exp_rdata = rv.wr ? 32'h0 : rv.rdat;
      rv.exp_err   = rv.resp[1];
      rv.exp_lat   = model_lat(rv);
      apply(rv, $sformatf("rnd%0d", i));
    end

    // unexpected responses while idle
    b0 = b_n; r0 = r_n; rdy0 = rdy_n;
    stray = 1'b1;
    repeat (4) @(negedge clk);
    stray = 1'b0;
    @(negedge clk);
    check("stray_resp",
          {8'(b_n - b0), 8'(r_n - r0), 8'(rdy_n - rdy0)},
          64'(0));

    // valid dropped and fields changed mid-read
    rv = zv;
    rv.ar_w = 2; rv.rdat = 32'h600DCAFE;
    set_cfg(rv);
    ar0 = ar_n; aw0 = aw_n;
    @(negedge clk);
    reg_bus.write = 0; reg_bus.addr = 32'h50;
    reg_bus.valid = 1;
    @(negedge clk);
    reg_bus.valid = 0; reg_bus.write = 1;
    reg_bus.addr = 32'hFFFFFFF0;
    wait_ready(lat, first, to);
    check("drop_timeout", 64'(to), 64'(0));
    check("drop_latency", 64'(lat), 64'(4));
    check("drop_rdata", 64'(reg_bus.rdata), 64'(32'h600DCAFE));
    check("drop_ar_addr", 64'(ar_log[$]), 64'(32'h50));
    check("drop_counts", {8'(ar_n - ar0), 8'(aw_n - aw0)},
          {8'd1, 8'd0});

    // back-to-back with valid held high
    repeat (2) @(negedge clk);
    set_cfg(zv);
    ar0 = ar_n; aw0 = aw_n; rdy0 = rdy_n;
    reg_bus.write = 1; reg_bus.addr = 32'h0;
    reg_bus.wdata = 32'h1; reg_bus.wstrb = 4'hF;
    reg_bus.valid = 1;
    wait_ready(lat, first, to);
    check("b2b_wr_timeout", 64'(to), 64'(0));
    reg_bus.write = 0;
    cfg_rdat = 32'h00000001;
    wait_ready(lat, first, to);
    check("b2b_rd_timeout", 64'(to), 64'(0));
    check("b2b_ar_offset", 64'(first), 64'(2));
    check("b2b_gap", 64'(lat), 64'(4));
    check("b2b_rdata", 64'(reg_bus.rdata), 64'(1));
    @(negedge clk);
    reg_bus.valid = 0;
    repeat (6) @(negedge clk);
    check("b2b_counts",
          {8'(aw_n - aw0), 8'(ar_n - ar0), 8'(rdy_n - rdy0)},
          {8'd1, 8'd1, 8'd2});
    check("b2b_ar_addr", 64'(ar_log[$]), 64'(0));

    // reset while waiting for B
    apply(tbl[1], "pre_rst");
    rv = zv;
    rv.b_w = 6;
    set_cfg(rv);
    @(negedge clk);
    reg_bus.write = 1; reg_bus.addr = 32'h60;
    reg_bus.wdata = 32'h99; reg_bus.valid = 1;
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (axi.b_ready) begin
        to = 1'b0;
        break;
      end
    end
    check("rst_reach_wr_resp", 64'(to), 64'(0));
    rdy0 = rdy_n;
    rst = 1'b1;
    reg_bus.valid = 0;
    @(negedge clk);
    check("rst_mid_outputs", out_bus(), 64'(0));
    rst = 1'b0;
    check("rst_no_ready", 64'(rdy_n - rdy0), 64'(0));
    apply(tbl[6], "post_rst");

    check("protocol_clean", 64'(viol_n), 64'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
